// File: rtl/arith_pkg.sv
// Shared opcode, state and width definitions for the arithmetic sequencer.
package arith_pkg;

  localparam int WIDTH = 16;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_B2A  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    HOLD  = 2'b11
  } state_t;

endpackage

// File: rtl/adder_subtractor_16bit.sv
// 16-bit adder/subtractor: carryIn high inverts b, giving a + ~b + 1.
module adder_subtractor_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carryIn,
  output logic [15:0] sum,
  output logic        carryOut
);

  logic [15:0] b_eff;

  always_comb begin
    b_eff = b ^ {16{carryIn}};
    {carryOut, sum} = {1'b0, a} + {1'b0, b_eff} + {16'b0, carryIn};
  end

endmodule

// File: rtl/arith_op_sequencer.sv
// Handshaked front-end that time-multiplexes one adder_subtractor_16bit
// over one pass (ADD/SUB) or two passes (B2A = b - 2a).
module arith_op_sequencer
  import arith_pkg::*;
#(
  parameter int WIDTH = arith_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  state_t state, next_state;

  logic [WIDTH-1:0] a_reg, b_reg, s2a;
  logic [1:0]       op_reg;

  logic [WIDTH-1:0] add_x, add_y, add_sum;
  logic             add_cin, add_cout;

  assign in_ready = (state == IDLE);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (in_valid) next_state = PASS1;
      PASS1: next_state = (op_reg == OP_B2A) ? PASS2 : HOLD;
      PASS2: next_state = HOLD;
      HOLD:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand steering; the adder inverts add_y itself when add_cin is set.
  always_comb begin
    add_x   = a_reg;
    add_y   = b_reg;
    add_cin = 1'b0;
    if (state == PASS2) begin
      add_x   = b_reg;
      add_y   = s2a;
      add_cin = 1'b1;
    end else begin
      unique case (op_reg)
        OP_SUB: add_cin = 1'b1;
        OP_B2A: add_y   = a_reg;
        default: add_cin = 1'b0;
      endcase
    end
  end

  adder_subtractor_16bit u_adder (
    .a        (add_x),
    .b        (add_y),
    .carryIn  (add_cin),
    .sum      (add_sum),
    .carryOut (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_ADD;
      s2a       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
          end
        end
        PASS1: begin
          // B2A's doubling carry is dropped; only the final pass reports one.
          if (op_reg == OP_B2A) begin
            s2a <= add_sum;
          end else begin
            result    <= add_sum;
            carry_out <= add_cout;
            zero      <= (add_sum == '0);
            out_valid <= 1'b1;
          end
        end
        PASS2: begin
          result    <= add_sum;
          carry_out <= add_cout;
          zero      <= (add_sum == '0);
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Directed, table-driven bench for arith_op_sequencer with backpressure and reset sequences.
module tb_arith_op_sequencer;
  import arith_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_result;
    logic        exp_carry;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  arith_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Accepts one op, measures latency, checks result, then completes the output handshake.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({tag, " result"}, 32'(result), 32'(v.exp_result));
    checkOutput({tag, " carry_out"}, 32'(carry_out), 32'(v.exp_carry));
    checkOutput({tag, " zero"}, 32'(zero), 32'(v.exp_zero));
    checkOutput({tag, " in_ready in HOLD"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    checkOutput({tag, " result kept"}, 32'(result), 32'(v.exp_result));
  endtask

  initial begin
    vec_t v;
    int lat;
    logic [15:0] held_result;

    vecs[0] = '{OP_ADD,  16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0, 2};
    vecs[1] = '{OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 2};
    vecs[2] = '{OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 2};
    vecs[3] = '{OP_B2A,  16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b0, 3};
    vecs[4] = '{OP_RSVD, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 2};
    vecs[5] = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 2};
    vecs[6] = '{OP_B2A,  16'h0003, 16'h000A, 16'h0004, 1'b1, 1'b0, 3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset carry_out", 32'(carry_out), 32'd0);
    checkOutput("reset zero", 32'(zero), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Async reset during PASS2 of a B2A; previous result 0x0004/carry 1 must clear without an edge.
    @(negedge clk);
    op = OP_B2A; a = 16'h0003; b = 16'h000A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("async rst result", 32'(result), 32'd0);
    checkOutput("async rst carry_out", 32'(carry_out), 32'd0);
    checkOutput("async rst zero", 32'(zero), 32'd0);
    checkOutput("async rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 2};
    applyStimulus(v, "post-reset add");

    // Backpressure: stall 5 cycles while upstream inputs churn.
    @(negedge clk);
    op = OP_ADD; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp latency", 32'(lat), 32'd2);
    held_result = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a = 16'(c * 16'h1111 + 16'h0101);
      b = 16'(c + 3);
      op = 2'(c);
      in_valid = ~in_valid;
      @(posedge clk); #1;
      checkOutput($sformatf("bp out_valid c%0d", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp result c%0d", c), 32'(result), 32'(held_result));
      checkOutput($sformatf("bp carry c%0d", c), 32'(carry_out), 32'd1);
      checkOutput($sformatf("bp zero c%0d", c), 32'(zero), 32'd1);
      checkOutput($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp no stray capture", 32'(in_ready), 32'd1);
    checkOutput("bp result retained", 32'(result), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
